rv_decode_stage: RTL and testbench

Registered RISC-V RV32I decode stage that turns a fetched instruction into a complete control word: ALU op, register-write, operand-B select, memory, branch/jump controls, register indices and the sign-extended immediate. It sits between fetch and execute, adds a valid/ready handshake, flush and illegal-instruction detection, and widens opcode coverage to loads, stores, branches and jumps. Every output is fully decoded each cycle; no control field holds a stale value.

---
 rtl/rv_ctrl_pkg.sv | 63 ++++++
 rtl/rv_imm_gen.sv | 32 +++
 rtl/rv_decode_stage.sv | 160 ++++++++++++++++
 tb/tb_rv_decode_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Purpose: shared opcodes, ALU codes, immediate formats and control-word layout for decode.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int ALU_W = 4;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b1001;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic             reg_wen;
    logic             b_sel;
    logic             mem_ren;
    logic             mem_wen;
    logic             branch;
    logic             jump;
    logic             illegal;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
  } ctrl_t;

  // funct3 -> ALU op; alt selects SUB/SRA where the encoding has an alternate form
  function automatic logic [ALU_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [ALU_W-1:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Purpose: extract the RV32I immediate for the selected format and sign-extend to XLEN.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module rv_imm_gen
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr_hi,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;

  // assemble a 32-bit signed immediate, then widen with the sign in bit 31
  always_comb begin
    raw = '0;
    case (fmt)
      IMM_I: raw = {{20{instr_hi[31]}}, instr_hi[31:20]};
      IMM_S: raw = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
      IMM_B: raw = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7], instr_hi[30:25],
                    instr_hi[11:8], 1'b0};
      IMM_U: raw = {instr_hi[31:12], 12'b0};
      IMM_J: raw = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12], instr_hi[20],
                    instr_hi[30:21], 1'b0};
      default: raw = '0;
    endcase
    imm = XLEN'($signed(raw));
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Purpose: registered RV32I decode turning an instruction into a full control word.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: holds the word while out_ready is low; in_ready = ~out_valid | out_ready; flush drops held and incoming.
module rv_decode_stage #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_wen,
  output logic               b_sel,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic               branch,
  output logic               jump,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [XLEN-1:0]    imm,
  output logic               illegal
);
  import rv_ctrl_pkg::*;

  ctrl_t           ctrl_d, ctrl_q;
  imm_fmt_t        fmt;
  logic [XLEN-1:0] imm_d, imm_q;
  logic            vld_q;
  logic            accept;
  logic [6:0]      opcode, f7;
  logic [2:0]      f3;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  assign in_ready = ~vld_q | out_ready;
  assign accept   = in_valid & in_ready;

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_hi (in_instr[31:7]),
    .fmt      (fmt),
    .imm      (imm_d)
  );

  // decode the instruction into a control word and immediate format
  always_comb begin
    ctrl_d     = '0;
    fmt        = IMM_NONE;
    ctrl_d.rd  = in_instr[11:7];
    ctrl_d.rs1 = in_instr[19:15];
    ctrl_d.rs2 = in_instr[24:20];
    case (opcode)
      OP_R: begin
        ctrl_d.reg_wen = 1'b1;
        ctrl_d.alu_op  = alu_from_f3(f3, f7 == F7_ALT);
        if (!(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))))
          ctrl_d.illegal = 1'b1;
      end
      OP_IALU: begin
        ctrl_d.reg_wen = 1'b1;
        ctrl_d.b_sel   = 1'b1;
        fmt            = IMM_I;
        // only the right shift has an alternate (arithmetic) form; ADDI has no SUB
        ctrl_d.alu_op  = alu_from_f3(f3, f3 == 3'b101 && f7 == F7_ALT);
        if (f3 == 3'b001 && f7 != F7_BASE)
          ctrl_d.illegal = 1'b1;
        if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)
          ctrl_d.illegal = 1'b1;
      end
      OP_LOAD: begin
        ctrl_d.reg_wen = 1'b1;
        ctrl_d.b_sel   = 1'b1;
        ctrl_d.mem_ren = 1'b1;
        ctrl_d.alu_op  = ALU_ADD;
        fmt            = IMM_I;
      end
      OP_STORE: begin
        ctrl_d.b_sel   = 1'b1;
        ctrl_d.mem_wen = 1'b1;
        ctrl_d.alu_op  = ALU_ADD;
        fmt            = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = ALU_SUB;
        fmt           = IMM_B;
      end
      OP_LUI: begin
        ctrl_d.reg_wen = 1'b1;
        ctrl_d.b_sel   = 1'b1;
        ctrl_d.alu_op  = ALU_ADD;
        fmt            = IMM_U;
      end
      OP_JAL: begin
        ctrl_d.reg_wen = 1'b1;
        ctrl_d.b_sel   = 1'b1;
        ctrl_d.jump    = 1'b1;
        ctrl_d.alu_op  = ALU_ADD;
        fmt            = IMM_J;
      end
      OP_JALR: begin
        ctrl_d.reg_wen = 1'b1;
        ctrl_d.b_sel   = 1'b1;
        ctrl_d.jump    = 1'b1;
        ctrl_d.alu_op  = ALU_ADD;
        fmt            = IMM_I;
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
    // an illegal word must have no side effects downstream; it only carries the trap
    if (ctrl_d.illegal) begin
      ctrl_d.reg_wen = 1'b0;
      ctrl_d.mem_ren = 1'b0;
      ctrl_d.mem_wen = 1'b0;
      ctrl_d.branch  = 1'b0;
      ctrl_d.jump    = 1'b0;
    end
    if (ctrl_d.rd == 5'd0)
      ctrl_d.reg_wen = 1'b0;
  end

  // output register with handshake; flush beats a same-cycle accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      imm_q  <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      ctrl_q <= ctrl_d;
      imm_q  <= imm_d;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign alu_op    = ALUOP_W'(ctrl_q.alu_op);
  assign reg_wen   = ctrl_q.reg_wen;
  assign b_sel     = ctrl_q.b_sel;
  assign mem_ren   = ctrl_q.mem_ren;
  assign mem_wen   = ctrl_q.mem_wen;
  assign branch    = ctrl_q.branch;
  assign jump      = ctrl_q.jump;
  assign illegal   = ctrl_q.illegal;
  assign rd        = ctrl_q.rd;
  assign rs1       = ctrl_q.rs1;
  assign rs2       = ctrl_q.rs2;
  assign imm       = imm_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Purpose: randomized scoreboard bench for rv_decode_stage against a behavioural decode model.
// Latency: expects the control word one cycle after accept.
// Backpressure: models in_ready/out_valid from the handshake rules and checks held words stay frozen.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [3:0]  alu_op;
  logic        reg_wen, b_sel, mem_ren, mem_wen, branch, jump, illegal;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .reg_wen(reg_wen), .b_sel(b_sel), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .branch(branch), .jump(jump), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .illegal(illegal)
  );

  localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_ADD = 4'd2, A_XOR = 4'd3, A_SLL = 4'd4,
                         A_SRL = 4'd5, A_SUB = 4'd6, A_SRA = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9;

  typedef struct {
    logic [3:0]  alu;
    logic        wen, bsel, ren, men, br, jmp, ill;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    bit          chk_alu, chk_bsel, chk_imm;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // reference decode written from the ISA rules, immediates computed arithmetically
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [3:0] tab [8];
    logic [6:0] op, f7;
    logic [2:0] f3;
    int x, v;
    tab = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    x  = int'(ins);
    e = '{alu: 4'd0, wen: 0, bsel: 0, ren: 0, men: 0, br: 0, jmp: 0, ill: 0,
          rd: ins[11:7], rs1: ins[19:15], rs2: ins[24:20], imm: 32'd0,
          chk_alu: 1, chk_bsel: 1, chk_imm: 1};
    case (op)
      7'h33: begin
        e.wen = 1; e.chk_imm = 0; e.alu = tab[f3];
        if (f7 == 7'h20 && f3 == 3'd0) e.alu = A_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = A_SRA;
        else if (f7 != 7'h00) e.ill = 1;
      end
      7'h13: begin
        e.wen = 1; e.bsel = 1; e.alu = tab[f3]; e.imm = 32'(x >>> 20);
        if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) e.alu = A_SRA;
          else if (f7 != 7'h00) e.ill = 1;
        end
      end
      7'h03: begin e.wen = 1; e.bsel = 1; e.ren = 1; e.alu = A_ADD; e.imm = 32'(x >>> 20); end
      7'h23: begin
        e.bsel = 1; e.men = 1; e.alu = A_ADD;
        e.imm = 32'(((x >>> 20) & ~31) | int'(ins[11:7]));
      end
      7'h63: begin
        e.br = 1; e.alu = A_SUB;
        v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        e.imm = 32'(v);
      end
      7'h37: begin e.wen = 1; e.bsel = 1; e.alu = A_ADD; e.imm = ins & 32'hFFFF_F000; end
      7'h6F: begin
        e.wen = 1; e.bsel = 1; e.jmp = 1; e.chk_alu = 0;
        v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
            + int'(ins[30:21]) * 2;
        e.imm = 32'(v);
      end
      7'h67: begin e.wen = 1; e.bsel = 1; e.jmp = 1; e.alu = A_ADD; e.imm = 32'(x >>> 20); end
      default: e.ill = 1;
    endcase
    if (e.ill) begin
      e.wen = 0; e.ren = 0; e.men = 0; e.br = 0; e.jmp = 0;
      e.chk_alu = 0; e.chk_bsel = 0; e.chk_imm = 0;
    end
    if (e.rd == 5'd0) e.wen = 0;
    return e;
  endfunction

  // scoreboard monitor: checks the presented word every cycle, then advances the model
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_rdy;
      exp_rdy = (sb.size() == 0) || out_ready;
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, sb.size() != 0);
      if (sb.size() != 0) begin
        if (sb[0].chk_alu)  chk("alu_op", alu_op, sb[0].alu);
        if (sb[0].chk_bsel) chk("b_sel", b_sel, sb[0].bsel);
        if (sb[0].chk_imm)  chk("imm", imm, sb[0].imm);
        chk("reg_wen", reg_wen, sb[0].wen);
        chk("mem_ren", mem_ren, sb[0].ren);
        chk("mem_wen", mem_wen, sb[0].men);
        chk("branch", branch, sb[0].br);
        chk("jump", jump, sb[0].jmp);
        chk("illegal", illegal, sb[0].ill);
        chk("regs", {rd, rs1, rs2}, {sb[0].rd, sb[0].rs1, sb[0].rs2});
      end
      if (flush) sb.delete();
      else begin
        if (sb.size() != 0 && out_ready) void'(sb.pop_front());
        if (in_valid && exp_rdy) sb.push_back(model(in_instr));
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [8];
    logic [31:0] ins;
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67};
    ins = $urandom;
    k = $urandom_range(0, 9);
    ins[6:0] = (k < 8) ? ops[k] : 7'($urandom);
    k = $urandom_range(0, 3);
    if (k == 0) ins[31:25] = 7'h00;
    else if (k == 1) ins[31:25] = 7'h20;
    return ins;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    #7;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ctrl", {alu_op, reg_wen, b_sel, mem_ren, mem_wen, branch, jump, illegal}, 0);
    chk("rst_regs_imm", {rd, rs1, rs2, imm}, 0);
    #5 rst = 1'b0;

    // directed words: add, sub, bad funct7, addi -1, nop, sw, beq -4
    step(1, 32'h002081B3, 1, 0);
    step(1, 32'h402081B3, 1, 0);
    step(1, 32'h202081B3, 1, 0);
    step(1, 32'hFFF00293, 1, 0);
    step(1, 32'h00000013, 1, 0);
    step(1, 32'h0020A423, 1, 0);
    step(1, 32'hFE000EE3, 1, 0);

    // back-pressure: hold for three cycles, then release
    step(1, 32'h00308233, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h40418333, 0, 0);
    step(1, 32'h40418333, 1, 0);
    step(0, 32'h0, 1, 0);

    // flush with a same-cycle accept, then flush of a held word
    step(1, 32'h00A00513, 1, 1);
    step(0, 32'h0, 1, 0);
    step(1, 32'h00B00593, 0, 0);
    step(0, 32'h0, 0, 1);
    step(0, 32'h0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);

    // reset mid-stream while a word is held
    step(1, 32'hFFF00293, 0, 0);
    step(0, 32'h0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_ctrl", {alu_op, reg_wen, b_sel, mem_ren, mem_wen, branch, jump, illegal}, 0);
    chk("mid_rst_regs_imm", {rd, rs1, rs2, imm}, 0);
    sb.delete();
    #3 rst = 1'b0;

    step(1, 32'h002081B3, 1, 0);
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
